// File: rtl/dm_rx_if.sv
// ---------------------------------------------------------------------------
// dm_rx_if : seven-segment display bus plus decoded fields  (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

interface dm_rx_if;
  logic [7:0]  an;
  logic [7:0]  dec_ddp;
  logic [2:0]  prog;
  logic [1:0]  modulo;
  logic [15:0] data_2;
  logic [7:0]  blank;
  logic        frame_done;
  logic        valid;
  logic        code_err;

  modport master (
    output an, dec_ddp,
    input  prog, modulo, data_2, blank, frame_done, valid, code_err
  );

  modport slave (
    input  an, dec_ddp,
    output prog, modulo, data_2, blank, frame_done, valid, code_err
  );
endinterface

`default_nettype wire

// File: rtl/dm_rx.sv
// ---------------------------------------------------------------------------
// dm_rx : samples, deglitches and decodes a multiplexed 8-digit 7-seg bus
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dm_rx #(
  parameter int         STABLE_CYC = 16,
  parameter logic [7:0] FRAME_MASK = 8'hFF
) (
  input  logic   clk,
  input  logic   rst,
  dm_rx_if.slave bus
);

  localparam logic [7:0] c_STABLE = 8'(STABLE_CYC);

  logic [7:0]  an_q, ddp_q, an_p_q, ddp_p_q;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] d2_q, d2_d;
  logic [1:0]  mod_q, mod_d;
  logic [2:0]  prog_q, prog_d;
  logic [7:0]  blank_q, blank_d;
  logic [7:0]  seen_q, seen_d;
  logic        frame_done_q, frame_done_d;
  logic        valid_q, valid_d;
  logic        code_err_q, code_err_d;

  logic        w_same, w_onehot, w_accept, w_is_hex, w_is_blank;
  logic [7:0]  w_sel, w_acc_bit, w_seen_new;
  logic [2:0]  w_idx;
  logic [3:0]  w_nib;

  always_comb begin
    w_same   = ({an_q, ddp_q} == {an_p_q, ddp_p_q});
    cnt_d    = w_same ? ((cnt_q == c_STABLE) ? cnt_q : cnt_q + 8'd1) : 8'd1;
    w_sel    = ~an_q;
    w_onehot = (w_sel != 8'd0) && ((w_sel & (w_sel - 8'd1)) == 8'd0);
    // Fires only on the cycle the counter first lands on STABLE_CYC.
    w_accept = (cnt_d == c_STABLE) && (cnt_q != c_STABLE) && w_onehot;
    w_idx    = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (w_sel[i]) w_idx = i[2:0];
    end
  end

  always_comb begin
    w_is_hex   = 1'b1;
    w_is_blank = 1'b0;
    w_nib      = 4'h0;
    case (ddp_q[7:1])
      7'b0000001: w_nib = 4'h0;
      7'b1001111: w_nib = 4'h1;
      7'b0010010: w_nib = 4'h2;
      7'b0000110: w_nib = 4'h3;
      7'b1001100: w_nib = 4'h4;
      7'b0100100: w_nib = 4'h5;
      7'b0100000: w_nib = 4'h6;
      7'b0001111: w_nib = 4'h7;
      7'b0000000: w_nib = 4'h8;
      7'b0000100: w_nib = 4'h9;
      7'b0001000: w_nib = 4'hA;
      7'b1100000: w_nib = 4'hB;
      7'b0110001: w_nib = 4'hC;
      7'b1000010: w_nib = 4'hD;
      7'b0110000: w_nib = 4'hE;
      7'b0111000: w_nib = 4'hF;
      7'b1111111: begin
        w_is_hex   = 1'b0;
        w_is_blank = 1'b1;
      end
      default:    w_is_hex = 1'b0;
    endcase
  end

  always_comb begin
    d2_d         = d2_q;
    mod_d        = mod_q;
    prog_d       = prog_q;
    blank_d      = blank_q;
    valid_d      = valid_q;
    code_err_d   = 1'b0;
    frame_done_d = 1'b0;
    w_acc_bit    = 8'd0;
    if (w_accept) begin
      if (w_is_hex) begin
        case (w_idx)
          3'd0:    d2_d[3:0]   = w_nib;
          3'd1:    d2_d[7:4]   = w_nib;
          3'd2:    d2_d[11:8]  = w_nib;
          3'd3:    d2_d[15:12] = w_nib;
          3'd5:    mod_d       = w_nib[1:0];
          3'd7:    prog_d      = w_nib[2:0];
          default: ;
        endcase
        blank_d[w_idx]   = 1'b0;
        w_acc_bit[w_idx] = 1'b1;
      end else if (w_is_blank) begin
        blank_d[w_idx]   = 1'b1;
        w_acc_bit[w_idx] = 1'b1;
      end else begin
        code_err_d = 1'b1;
      end
    end
    w_seen_new = seen_q | w_acc_bit;
    seen_d     = w_seen_new;
    if ((w_seen_new & FRAME_MASK) == FRAME_MASK) begin
      frame_done_d = 1'b1;
      seen_d       = 8'd0;
      valid_d      = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_q         <= 8'hFF;
      ddp_q        <= 8'hFF;
      an_p_q       <= 8'hFF;
      ddp_p_q      <= 8'hFF;
      cnt_q        <= 8'd0;
      d2_q         <= 16'd0;
      mod_q        <= 2'd0;
      prog_q       <= 3'd0;
      blank_q      <= 8'hFF;
      seen_q       <= 8'd0;
      frame_done_q <= 1'b0;
      valid_q      <= 1'b0;
      code_err_q   <= 1'b0;
    end else begin
      an_q         <= bus.an;
      ddp_q        <= bus.dec_ddp;
      an_p_q       <= an_q;
      ddp_p_q      <= ddp_q;
      cnt_q        <= cnt_d;
      d2_q         <= d2_d;
      mod_q        <= mod_d;
      prog_q       <= prog_d;
      blank_q      <= blank_d;
      seen_q       <= seen_d;
      frame_done_q <= frame_done_d;
      valid_q      <= valid_d;
      code_err_q   <= code_err_d;
    end
  end

  assign bus.data_2     = d2_q;
  assign bus.modulo     = mod_q;
  assign bus.prog       = prog_q;
  assign bus.blank      = blank_q;
  assign bus.frame_done = frame_done_q;
  assign bus.valid      = valid_q;
  assign bus.code_err   = code_err_q;

endmodule

`default_nettype wire

// File: tb/tb_dm_rx.sv
// ---------------------------------------------------------------------------
// tb_dm_rx : table-driven self-checking bench for dm_rx  (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dm_rx;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dm_rx_if bus ();

  dm_rx #(.STABLE_CYC(16), .FRAME_MASK(8'hFF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [7:0]  an;
    logic [7:0]  ddp;
    int          hold;
    logic [15:0] d2;
    logic [1:0]  md;
    logic [2:0]  pg;
    logic [7:0]  blk;
    int          fd;
    int          ce;
    logic        vld;
  } vec_t;

  vec_t tbl[19];

  int n_chk  = 0;
  int n_fail = 0;
  int fd_cnt = 0;
  int ce_cnt = 0;

  always @(posedge clk) begin
    if (bus.frame_done) fd_cnt <= fd_cnt + 1;
    if (bus.code_err)   ce_cnt <= ce_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] d, input int hold);
    bus.an      = a;
    bus.dec_ddp = d;
    repeat (hold) @(negedge clk);
  endtask

  task automatic run_row(input int r);
    int fd0, ce0;
    fd0 = fd_cnt;
    ce0 = ce_cnt;
    drive(tbl[r].an, tbl[r].ddp, tbl[r].hold);
    chk($sformatf("row%0d data_2", r), 32'(bus.data_2), 32'(tbl[r].d2));
    chk($sformatf("row%0d modulo", r), 32'(bus.modulo), 32'(tbl[r].md));
    chk($sformatf("row%0d prog", r), 32'(bus.prog), 32'(tbl[r].pg));
    chk($sformatf("row%0d blank", r), 32'(bus.blank), 32'(tbl[r].blk));
    chk($sformatf("row%0d frame_done pulses", r), 32'(fd_cnt - fd0), 32'(tbl[r].fd));
    chk($sformatf("row%0d code_err pulses", r), 32'(ce_cnt - ce0), 32'(tbl[r].ce));
    chk($sformatf("row%0d valid", r), 32'(bus.valid), 32'(tbl[r].vld));
  endtask

  initial begin
    int fd0, ce0, lat;

    // first clean frame
    tbl[0]  = '{8'hFE, 8'h99, 40, 16'h0004, 2'd0, 3'd0, 8'hFE, 0, 0, 1'b0};
    tbl[1]  = '{8'hFD, 8'h0D, 40, 16'h0034, 2'd0, 3'd0, 8'hFC, 0, 0, 1'b0};
    tbl[2]  = '{8'hFB, 8'h25, 40, 16'h0234, 2'd0, 3'd0, 8'hF8, 0, 0, 1'b0};
    tbl[3]  = '{8'hF7, 8'h9F, 40, 16'h1234, 2'd0, 3'd0, 8'hF0, 0, 0, 1'b0};
    tbl[4]  = '{8'hEF, 8'hFF, 40, 16'h1234, 2'd0, 3'd0, 8'hF0, 0, 0, 1'b0};
    tbl[5]  = '{8'hDF, 8'h9F, 40, 16'h1234, 2'd1, 3'd0, 8'hD0, 0, 0, 1'b0};
    tbl[6]  = '{8'hBF, 8'hFF, 40, 16'h1234, 2'd1, 3'd0, 8'hD0, 0, 0, 1'b0};
    tbl[7]  = '{8'h7F, 8'h49, 40, 16'h1234, 2'd1, 3'd5, 8'h50, 1, 0, 1'b1};
    // illegal selects, then a bad glyph on #1
    tbl[8]  = '{8'hF3, 8'h49, 50, 16'h1234, 2'd1, 3'd5, 8'h50, 0, 0, 1'b1};
    tbl[9]  = '{8'hFF, 8'hFF, 50, 16'h1234, 2'd1, 3'd5, 8'h50, 0, 0, 1'b1};
    tbl[10] = '{8'hFE, 8'hAB, 30, 16'h1234, 2'd1, 3'd5, 8'h50, 0, 1, 1'b1};
    // #2..#8 again: frame must wait for #1
    tbl[11] = '{8'hFD, 8'h0D, 40, 16'h1234, 2'd1, 3'd5, 8'h50, 0, 0, 1'b1};
    tbl[12] = '{8'hFB, 8'h25, 40, 16'h1234, 2'd1, 3'd5, 8'h50, 0, 0, 1'b1};
    tbl[13] = '{8'hF7, 8'h9F, 40, 16'h1234, 2'd1, 3'd5, 8'h50, 0, 0, 1'b1};
    tbl[14] = '{8'hEF, 8'hFF, 40, 16'h1234, 2'd1, 3'd5, 8'h50, 0, 0, 1'b1};
    tbl[15] = '{8'hDF, 8'h9F, 40, 16'h1234, 2'd1, 3'd5, 8'h50, 0, 0, 1'b1};
    tbl[16] = '{8'hBF, 8'hFF, 40, 16'h1234, 2'd1, 3'd5, 8'h50, 0, 0, 1'b1};
    tbl[17] = '{8'h7F, 8'h49, 40, 16'h1234, 2'd1, 3'd5, 8'h50, 0, 0, 1'b1};
    // "0" with decimal point lit completes the frame
    tbl[18] = '{8'hFE, 8'h02, 40, 16'h1230, 2'd1, 3'd5, 8'h50, 1, 0, 1'b1};

    rst         = 1'b1;
    bus.an      = 8'($urandom);
    bus.dec_ddp = 8'($urandom);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("reset data_2", 32'(bus.data_2), 32'h0);
      chk("reset modulo/prog", 32'({bus.modulo, bus.prog}), 32'h0);
      chk("reset blank", 32'(bus.blank), 32'hFF);
      chk("reset valid/pulses", 32'({bus.valid, bus.frame_done, bus.code_err}), 32'h0);
      bus.an      = 8'($urandom);
      bus.dec_ddp = 8'($urandom);
    end
    bus.an      = 8'hFF;
    bus.dec_ddp = 8'hFF;
    rst         = 1'b0;
    repeat (4) @(negedge clk);

    for (int r = 0; r < 19; r++) run_row(r);

    // glitch filter: 15-cycle dwell rejected, 16-cycle dwell accepted
    ce0 = ce_cnt;
    drive(8'hFE, 8'h1F, 15);
    drive(8'hFF, 8'hFF, 40);
    chk("glitch short dwell data_2", 32'(bus.data_2), 32'h1230);
    drive(8'hFE, 8'h1F, 16);
    drive(8'hFF, 8'hFF, 40);
    chk("glitch exact dwell data_2", 32'(bus.data_2), 32'h1237);
    chk("glitch code_err pulses", 32'(ce_cnt - ce0), 32'h0);

    // reset mid-frame after #1..#5
    for (int r = 0; r < 5; r++) drive(tbl[r].an, tbl[r].ddp, tbl[r].hold);
    chk("pre-reset data_2", 32'(bus.data_2), 32'h1234);
    bus.an      = 8'hFF;
    bus.dec_ddp = 8'hFF;
    rst         = 1'b1;
    repeat (3) @(negedge clk);
    chk("midreset data_2", 32'(bus.data_2), 32'h0);
    chk("midreset blank", 32'(bus.blank), 32'hFF);
    chk("midreset valid", 32'(bus.valid), 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    for (int r = 0; r < 7; r++) run_row(r);

    // last digit: frame_done exactly STABLE_CYC+1 edges after settling
    fd0         = fd_cnt;
    lat         = 0;
    bus.an      = 8'h7F;
    bus.dec_ddp = 8'h49;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.frame_done && lat == 0) lat = k;
    end
    @(negedge clk);
    chk("frame_done latency", 32'(lat), 32'd17);
    chk("post-reset frame pulses", 32'(fd_cnt - fd0), 32'd1);
    chk("post-reset prog", 32'(bus.prog), 32'd5);
    chk("post-reset blank", 32'(bus.blank), 32'h50);
    chk("post-reset valid", 32'(bus.valid), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dm_rx.md
Name: dm_rx

Overview:
- Receive-side counterpart of the multiplexed 8-digit seven-segment display interface driven by the display manager.
- Samples the time-multiplexed anode select and cathode pattern buses, filters switching glitches, and decodes each digit back to a hex nibble.
- Rebuilds the prog, modulo and data_2 fields carried by that interface.
- Used in loopback self-test and as a bench monitor on the display bus.

Parameters:
- STABLE_CYC, 16: consecutive identical samples of {an, dec_ddp} required before a digit is accepted. Legal range 2..255.
- FRAME_MASK, 8'hFF: digits (bit i = display #i+1) that must be accepted before a frame completes.

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  reset, asynchronous, active-high
- an  in  8  anode select, active-low; bit i = display #i+1
- dec_ddp  in  8  cathodes, active-low; [7:1] = segments a..g, [0] = decimal point
- prog  out  3  decoded nibble of display #8, bits [2:0]
- modulo  out  2  decoded nibble of display #6, bits [1:0]
- data_2  out  16  {display #4, #3, #2, #1} nibbles; #4 is most significant
- blank  out  8  bit i = 1 when digit i was last accepted as all segments off
- frame_done  out  1  one-cycle pulse when every FRAME_MASK digit has been accepted since the last pulse
- valid  out  1  high from the first frame_done until reset
- code_err  out  1  one-cycle pulse when a stable segment pattern is neither a hex glyph nor blank

Behaviour:
- Reset values (asynchronous, while rst=1):
  - prog=0, modulo=0, data_2=0, blank=8'hFF.
  - frame_done=0, valid=0, code_err=0.
  - Internal digit registers=0, seen mask=0, stability counter=0, input registers=8'hFF/8'hFF.
- Stage 1 (input capture): an and dec_ddp are registered every cycle.
- Stage 2 (stability filter):
  - When the registered sample equals the previous registered sample, the counter increments, saturating at STABLE_CYC.
  - Otherwise the counter resets to 1.
  - Accept event: the counter reaches exactly STABLE_CYC. It fires once per stable dwell; re-arm only after a sample change.
- Select legality:
  - A sample is a digit candidate only if an has exactly one bit low.
  - an=8'hFF (all off) or multiple bits low is never accepted. The counter still runs, but no accept fires.
- Glyph decode (dec_ddp[7:1], a..g, active-low): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000. dec_ddp[0] is ignored.
- On accept for digit i:
  - Hex glyph: digit register i takes the nibble, blank[i]=0, seen[i]=1.
  - Blank (1111111): digit register i is unchanged, blank[i]=1, seen[i]=1.
  - Any other pattern: code_err pulses, registers unchanged, seen unchanged.
- Outputs are driven directly from the digit registers and update on the cycle after the accept cycle.
  - Total latency from the bus settling to the output update: STABLE_CYC+1 clk edges.
- Frame completion:
  - When (seen | new accept bit) & FRAME_MASK == FRAME_MASK, frame_done pulses in the same cycle as the output update.
  - Seen is cleared to 0 in that same cycle, and valid is set.
  - An accept arriving in the clearing cycle is lost only if it is for a different digit. This cannot occur, because accepts are at least STABLE_CYC cycles apart.
- Repeated accepts of the same digit within one frame overwrite the value; this does not affect frame counting beyond seen.
- If rst asserts mid-frame, all state returns to reset values; the next frame starts from an empty seen mask.
- Implementation: single clock domain, no combinational path from input ports to output ports.

Test Plan:
- Reset: rst=1 for 3 cycles with random bus -> prog=0, modulo=0, data_2=0, blank=FF, valid=0, no pulses.
- Clean frame, each digit held 40 cycles in order #1..#8:
  - #1 "4"=0x99, #2 "3"=0x0D, #3 "2"=0x25, #4 "1"=0x9F, #5 blank 0xFF, #6 "1"=0x9F, #7 blank, #8 "5"=0x49.
  - Required: data_2=16'h1234, modulo=1, prog=5, blank=8'b0101_0000.
  - frame_done pulses exactly once, STABLE_CYC+1 edges after #8 settles; valid=1.
- Glitch filter: a digit held STABLE_CYC-1 cycles, then the anode changes -> no update. A digit held exactly STABLE_CYC cycles -> the update occurs.
- Illegal select: an=8'b1111_0011 held 50 cycles, then an=8'hFF held 50 cycles -> no accept, no code_err, outputs unchanged.
- Bad glyph: an=8'hFE with dec_ddp=0xAB held 30 cycles -> one code_err pulse, data_2[3:0] unchanged, seen[0] stays 0, so frame_done is delayed accordingly.
- Reset mid-frame: digits #1..#5 accepted, rst pulsed, then a full frame -> frame_done only after all 8 digits are re-accepted post-reset.
